// File: rtl/gaussian_pkg.sv
// Shared types and constants for the Gaussian blur stage: sequencer state
// encoding, kernel-select codes and the kernel half-width decode.
package gaussian_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ROW   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KSEL_3X3  = 2'd0,
        KSEL_5X5  = 2'd1,
        KSEL_7X7  = 2'd2,
        KSEL_RSVD = 2'd3
    } ksel_e;

    localparam int DEF_ROWS       = 480;
    localparam int DEF_ADDR_W     = 9;
    localparam int DEF_ROW_CYCLES = 10;
    localparam int DEF_PH_W       = 4;

    // Reserved code decodes as 3x3 so a bad select still produces a sane frame.
    function automatic logic [1:0] ksel_to_half(input logic [1:0] ksel);
        logic [1:0] h;
        case (ksel_e'(ksel))
            KSEL_5X5: h = 2'd2;
            KSEL_7X7: h = 2'd3;
            default:  h = 2'd1;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/gaussian_blur_seq_if.sv
// Control bus between the scale FSM (master) and the blur row sequencer
// (slave), including the SRAM / line-buffer strobes the sequencer drives.
interface gaussian_blur_seq_if #(
    parameter int ADDR_W = 9,
    parameter int PH_W   = 4
);
    logic              start;
    logic              abort;
    logic [1:0]        ksel;
    logic              busy;
    logic              done;
    logic              clear_buf;
    logic              img_re;
    logic [ADDR_W-1:0] img_addr;
    logic              buf_we;
    logic              fill_zero;
    logic [PH_W-1:0]   phase;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output start, abort, ksel,
        input  busy, done, clear_buf, img_re, img_addr, buf_we, fill_zero,
               phase, out_we, out_addr
    );

    modport slave (
        input  start, abort, ksel,
        output busy, done, clear_buf, img_re, img_addr, buf_we, fill_zero,
               phase, out_we, out_addr
    );
endinterface

// File: rtl/blur_phase_cnt.sv
// Modulo-ROW_CYCLES compute-phase counter with flags for the row prefetch
// slot (second-to-last phase) and the write/shift slot (last phase).
module blur_phase_cnt #(
    parameter int ROW_CYCLES = 10,
    parameter int PH_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            clr_i,
    output logic [PH_W-1:0] phase_o,
    output logic            last_o,
    output logic            prefetch_o
);
    logic [PH_W-1:0] phase_q, phase_d;

    assign last_o     = (phase_q == PH_W'(ROW_CYCLES - 1));
    assign prefetch_o = (phase_q == PH_W'(ROW_CYCLES - 2));
    assign phase_o    = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (clr_i)
            phase_d = '0;
        else if (en_i)
            phase_d = last_o ? '0 : phase_q + PH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            phase_q <= '0;
        else
            phase_q <= phase_d;
    end
endmodule

// File: rtl/gaussian_blur_seq.sv
// Row sequencer for the Gaussian blur stage: primes the line buffers, then
// per output row prefetches the next image row (or a zero row) and writes.
module gaussian_blur_seq
    import gaussian_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ROW_CYCLES = DEF_ROW_CYCLES,
    parameter int PH_W       = DEF_PH_W
) (
    input  logic               clk,
    input  logic               rst,
    gaussian_blur_seq_if.slave bus
);
    localparam int FW = ADDR_W + 2;

    state_e            state_q, state_d;
    logic [1:0]        h_q, h_d;
    logic [2:0]        pc_q, pc_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d, img_addr_n;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d, out_addr_n;

    logic            clear_buf, img_re, buf_we, fill_zero, out_we, done;
    logic            cnt_en, cnt_clr, ph_last, ph_pref;
    logic [PH_W-1:0] phase;
    logic [FW-1:0]   f_row;
    logic            f_in, last_fetch, leaving;

    // Row entering the window for the next output row; past the bottom edge
    // it becomes a zero row instead of an SRAM fetch.
    assign f_row      = FW'(row_q) + FW'(h_q) + FW'(1);
    assign f_in       = (f_row < FW'(ROWS));
    assign last_fetch = (pc_q == {h_q, 1'b1});

    blur_phase_cnt #(
        .ROW_CYCLES (ROW_CYCLES),
        .PH_W       (PH_W)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .en_i       (cnt_en),
        .clr_i      (cnt_clr),
        .phase_o    (phase),
        .last_o     (ph_last),
        .prefetch_o (ph_pref)
    );

    assign cnt_en  = (state_q == ST_ROW);
    assign cnt_clr = (state_d != ST_ROW);

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        pc_d       = pc_q;
        row_d      = row_q;
        clear_buf  = 1'b0;
        img_re     = 1'b0;
        buf_we     = 1'b0;
        fill_zero  = 1'b0;
        out_we     = 1'b0;
        done       = 1'b0;
        img_addr_n = img_addr_q;
        out_addr_n = out_addr_q;

        case (state_q)
            ST_IDLE: begin
                pc_d  = '0;
                row_d = '0;
                if (bus.start) begin
                    clear_buf = 1'b1;
                    h_d       = ksel_to_half(bus.ksel);
                    state_d   = ST_PRIME;
                end
            end
            ST_PRIME: begin
                pc_d = pc_q + 3'd1;
                if (!pc_q[0]) begin
                    img_re     = 1'b1;
                    img_addr_n = ADDR_W'(pc_q[2:1]);
                end else begin
                    buf_we = 1'b1;
                    if (last_fetch) begin
                        pc_d    = '0;
                        state_d = ST_ROW;
                    end
                end
            end
            ST_ROW: begin
                if (ph_pref) begin
                    if (f_in) begin
                        img_re     = 1'b1;
                        img_addr_n = f_row[ADDR_W-1:0];
                    end else begin
                        fill_zero = 1'b1;
                    end
                end
                if (ph_last) begin
                    fill_zero  = !f_in;
                    buf_we     = 1'b1;
                    out_we     = 1'b1;
                    out_addr_n = row_q;
                    row_d      = row_q + ADDR_W'(1);
                    if (row_q == ADDR_W'(ROWS - 1))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort outranks everything, including the DONE pulse itself.
        if (state_q != ST_IDLE && bus.abort) begin
            state_d = ST_IDLE;
            done    = 1'b0;
        end
    end

    assign leaving    = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign img_addr_d = leaving ? '0 : img_addr_n;
    assign out_addr_d = leaving ? '0 : out_addr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            h_q        <= 2'd1;
            pc_q       <= '0;
            row_q      <= '0;
            img_addr_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            pc_q       <= pc_d;
            row_q      <= row_d;
            img_addr_q <= img_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done;
    assign bus.clear_buf = clear_buf;
    assign bus.img_re    = img_re;
    assign bus.img_addr  = img_addr_n;
    assign bus.buf_we    = buf_we;
    assign bus.fill_zero = fill_zero;
    assign bus.phase     = phase;
    assign bus.out_we    = out_we;
    assign bus.out_addr  = out_addr_n;
endmodule

// File: tb/tb_gaussian_blur_seq.sv
// Bench for the blur row sequencer: table of kernel runs plus abort, reset
// and start/abort collision sequences, with a read/write address scoreboard.
module tb_gaussian_blur_seq;
    localparam int ROWS   = 8;
    localparam int ADDR_W = 3;
    localparam int RC     = 4;
    localparam int PH_W   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gaussian_blur_seq_if #(.ADDR_W(ADDR_W), .PH_W(PH_W)) bus();

    gaussian_blur_seq #(
        .ROWS       (ROWS),
        .ADDR_W     (ADDR_W),
        .ROW_CYCLES (RC),
        .PH_W       (PH_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int rd_q[$];
    int wr_q[$];
    int fz_cnt;
    int done_cnt;
    int done_cyc;

    typedef struct {
        logic [1:0] ksel;
        logic [1:0] mid_ksel;
        bit         mid_start;
        int         exp_h;
        int         exp_lat;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int outs();
        return int'({bus.busy, bus.done, bus.clear_buf, bus.img_re, bus.img_addr,
                     bus.buf_we, bus.fill_zero, bus.phase, bus.out_we, bus.out_addr});
    endfunction

    // Scoreboard side: every strobe consumes the next expected address.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.img_re) begin
                if (rd_q.size() == 0) chk("img_re_extra", 1, 0);
                else chk("img_addr", int'(bus.img_addr), rd_q.pop_front());
            end
            if (bus.out_we) begin
                if (wr_q.size() == 0) chk("out_we_extra", 1, 0);
                else chk("out_addr", int'(bus.out_addr), wr_q.pop_front());
            end
            if (bus.fill_zero) chk("fz_excl", int'(bus.img_re), 0);
            if (bus.buf_we && bus.fill_zero) fz_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!bus.busy)
                chk("idle_strobe", int'({bus.img_re, bus.fill_zero, bus.out_we}), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep();
        rd_q.delete();
        wr_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            rd_q.push_back(r);
            wr_q.push_back(r);
        end
        fz_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic start_run(input logic [1:0] k, output int t0);
        prep();
        bus.ksel  = k;
        bus.start = 1'b1;
        @(negedge clk);
        chk("clear_buf", int'(bus.clear_buf), 1);
        t0 = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int exp_lat, input int exp_h);
        int i;
        i = 0;
        while (done_cnt == 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("done_seen", done_cnt, 1);
        chk("latency", done_cyc - t0, exp_lat);
        @(negedge clk);
        chk("done_single", done_cnt, 1);
        chk("idle_after", int'(bus.busy), 0);
        chk("addr_zeroed", int'({bus.img_addr, bus.out_addr}), 0);
        chk("fill_rows", fz_cnt, exp_h + 1);
        chk("reads_left", rd_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
        tick();
    endtask

    initial begin
        int t0;
        vecs[0] = '{ksel: 2'd0, mid_ksel: 2'd1, mid_start: 1'b0, exp_h: 1, exp_lat: 37};
        vecs[1] = '{ksel: 2'd2, mid_ksel: 2'd2, mid_start: 1'b0, exp_h: 3, exp_lat: 41};
        vecs[2] = '{ksel: 2'd3, mid_ksel: 2'd3, mid_start: 1'b0, exp_h: 1, exp_lat: 37};
        vecs[3] = '{ksel: 2'd1, mid_ksel: 2'd1, mid_start: 1'b0, exp_h: 2, exp_lat: 39};
        vecs[4] = '{ksel: 2'd0, mid_ksel: 2'd2, mid_start: 1'b1, exp_h: 1, exp_lat: 37};
        vecs[5] = '{ksel: 2'd2, mid_ksel: 2'd0, mid_start: 1'b1, exp_h: 3, exp_lat: 41};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ksel  = 2'd0;
        prep();
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            start_run(vecs[v].ksel, t0);
            if (vecs[v].mid_start) begin
                repeat (12) tick();
                bus.ksel  = vecs[v].mid_ksel;
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end else begin
                bus.ksel = vecs[v].mid_ksel;
            end
            wait_done(t0, vecs[v].exp_lat, vecs[v].exp_h);
        end

        // Abort in ROW, 10 cycles after start: rows 0..2 fetched, row 0 written.
        start_run(2'd0, t0);
        repeat (9) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_outs", outs(), 0);
        chk("abort_reads_left", rd_q.size(), 5);
        chk("abort_writes_left", wr_q.size(), 7);
        tick();
        repeat (30) tick();
        chk("abort_no_done", done_cnt, 0);
        start_run(2'd0, t0);
        wait_done(t0, 37, 1);

        // Start and abort together in IDLE: start wins, a later abort cancels.
        prep();
        bus.ksel  = 2'd0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("start_wins", int'(bus.busy), 1);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("late_abort", outs(), 0);
        tick();
        repeat (5) tick();
        chk("late_abort_no_done", done_cnt, 0);

        // Synchronous reset in the middle of ROW.
        start_run(2'd1, t0);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", outs(), 0);
        tick();
        repeat (20) tick();
        chk("rst_no_done", done_cnt, 0);
        start_run(2'd2, t0);
        wait_done(t0, 41, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gaussian_blur_seq.md
Name: gaussian_blur_seq

Overview:
- Parametrised row sequencer for the Gaussian blur stage. It is the successor to the fixed 3x3 / 480-row / 10-phase controller.
- Drives image-SRAM reads, line-buffer shift, clear and zero-fill, the per-row compute phase, and blur-SRAM writes.
- Kernel size is selectable per run (3x3/5x5/7x7). Image height and compute cycles per row are parameters.
- Adds abort, busy, and a single-cycle done pulse. Sits between the top-level scale FSM and the line buffer / blur datapath.

Parameters:
- ROWS, 480, image rows per frame; must be >= 8.
- ADDR_W, 9, row address width; 2**ADDR_W >= ROWS.
- ROW_CYCLES, 10, datapath cycles per output row; must be >= 4.
- PH_W, 4, phase counter width; 2**PH_W >= ROW_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin run; sampled only in IDLE
- abort  in  1  cancel run; return to IDLE
- ksel  in  2  kernel select: 0=3x3, 1=5x5, 2=7x7, 3=reserved (treated as 3x3)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output row is written
- clear_buf  out  1  one-cycle pulse that zeroes all line buffers (top border)
- img_re  out  1  image SRAM read enable
- img_addr  out  ADDR_W  image row address
- buf_we  out  1  shift line buffers; load SRAM data, or zeros if fill_zero
- fill_zero  out  1  shift in a zero row (bottom border); mutually exclusive with img_re
- phase  out  PH_W  compute phase 0..ROW_CYCLES-1, valid in ROW state
- out_we  out  1  blur SRAM write enable
- out_addr  out  ADDR_W  blur SRAM row address

Behaviour:
- Reset: state IDLE. All outputs 0. Internal counters 0. Latched half-width H=1.
- Half-width H: 1, 2 or 3 for 3x3, 5x5, 7x7. Latched on the start cycle. A ksel change mid-run is ignored.
- Image SRAM read latency is 1 cycle. A read issued in cycle t is consumed by buf_we in cycle t+1.
- State IDLE:
  - start=1 -> clear_buf=1 in that same cycle; latch H; next state PRIME.
  - start=0 -> stay in IDLE.
- State PRIME: performs H+1 fetches of rows 0..H, two cycles per fetch.
  - Fetch cycle A: img_re=1, img_addr=k.
  - Fetch cycle B: buf_we=1.
  - After fetch H completes -> ROW, with phase=0 and out_row=0.
- State ROW: phase counts 0..ROW_CYCLES-1 and wraps.
  - At phase ROW_CYCLES-2, let f = out_row+H+1.
    - f < ROWS: img_re=1, img_addr=f.
    - Otherwise: fill_zero=1 and img_re=0. fill_zero stays high through the next cycle.
  - At phase ROW_CYCLES-1: out_we=1, out_addr=out_row, buf_we=1.
    - The write captures the current window before the shift takes effect.
    - Then out_row increments.
  - When out_row=ROWS-1 is written -> DONE.
- State DONE: done=1 for exactly one cycle -> IDLE.
- img_addr and out_addr hold their last value when the corresponding strobe is low. They are zeroed on entry to IDLE.
- Latency: done is high exactly 2(H+1) + ROWS*ROW_CYCLES + 1 cycles after the start cycle.
- Per run:
  - img_re count = ROWS.
  - fill_zero count = H+1.
  - out_we count = ROWS, with out_addr 0..ROWS-1 strictly ascending.
- abort:
  - In any non-IDLE state, next state is IDLE. No done pulse. Every strobe is 0 from the next cycle.
  - abort has priority over a same-cycle DONE transition; done is suppressed.
  - In IDLE, abort is ignored.
  - abort and start in the same IDLE cycle: start wins. A later abort cancels the run.
- start while busy is ignored and causes no restart.
- rst mid-run forces the reset state on the next edge. No done pulse.
- img_re, fill_zero and out_we are never asserted in IDLE.

Decomposition:
- Shared package gaussian_pkg:
  - State encoding: IDLE, PRIME, ROW, DONE.
  - ksel encodings.
  - Function ksel_to_half(ksel) returning H.
  - Default ROWS and ADDR_W constants, shared with the line buffer and blur datapath.
- One sub-module: blur_phase_cnt.
  - Modulo-ROW_CYCLES counter with enable and clear.
  - Outputs phase, last (phase==ROW_CYCLES-1) and prefetch (phase==ROW_CYCLES-2).
- The FSM, row counters and address registers stay in gaussian_blur_seq.

Test Plan:
- ROWS=8, ROW_CYCLES=4, ksel=0, start pulse:
  - PRIME reads rows 0,1. ROW fetches rows 2..7, then 2 fill_zero.
  - out_addr 0..7. done exactly 37 cycles after start.
- Same parameters, ksel=2:
  - PRIME reads rows 0..3. ROW fetches rows 4..7, then 4 fill_zero.
  - 8 out_we. done at start+41.
- ksel=3: behaves identically to ksel=0; done at start+37.
- abort asserted 10 cycles after start:
  - busy=0 the next cycle. No further img_re, out_we or done.
  - A new start then completes a full run with correct counts.
- start re-pulsed during ROW and ksel changed mid-run:
  - No restart.
  - Counts and done timing match the originally latched kernel.
- rst=1 for one cycle during ROW:
  - All outputs 0 next cycle, state IDLE, no done.
  - A subsequent run is unaffected.
